// File: rtl/con_bus_pkg.sv
// Shared types for the connection-bus controller: FSM states, a default-width
// beat view, and the beat-size helper used for energy accounting.
package con_bus_pkg;

  typedef enum logic [1:0] {
    RX      = 2'd0,
    TURN_TX = 2'd1,
    TX      = 2'd2,
    TURN_RX = 2'd3
  } con_state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_CONS   = 3;
  localparam int DEF_META_WIDTH = 16;

  typedef struct packed {
    logic [DEF_META_WIDTH-1:0]              meta;
    logic [DEF_NUM_CONS*DEF_DATA_WIDTH-1:0] data;
  } con_beat_t;

  function automatic int beat_bits(input int num_cons, input int data_width);
    return num_cons * data_width;
  endfunction

endpackage

// File: rtl/con_bus_ctrl_if.sv
// Bus-side and core-side handshake signals of the connection-bus controller.
// master = controller view, slave = environment/core view.
interface con_bus_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CONS   = 3,
  parameter int META_WIDTH = 16
);
  localparam int BW = NUM_CONS * DATA_WIDTH;

  logic [BW-1:0]         con_in;
  logic [BW-1:0]         con_out;
  logic                  dut_driving_cons;
  logic                  con_valid;
  logic                  con_ready;
  logic [BW-1:0]         rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [BW-1:0]         tx_data;
  logic [META_WIDTH-1:0] tx_meta;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  output_valid;
  logic [META_WIDTH-1:0] output_meta;

  modport master (
    input  con_in, con_valid, rx_ready, tx_data, tx_meta, tx_valid,
    output con_out, dut_driving_cons, con_ready, rx_data, rx_valid,
           tx_ready, output_valid, output_meta
  );

  modport slave (
    output con_in, con_valid, rx_ready, tx_data, tx_meta, tx_valid,
    input  con_out, dut_driving_cons, con_ready, rx_data, rx_valid,
           tx_ready, output_valid, output_meta
  );

endinterface

// File: rtl/con_tx_fifo.sv
// Synchronous result FIFO, combinational read of the head entry.
// Pointers carry an extra wrap bit; push while full is taken only alongside a pop.
module con_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/con_bus_ctrl.sv
// Bidirectional lane controller: receives env beats in RX, streams buffered results in TX.
// RX beat visible one cycle after accept; TX has no env backpressure, core sees tx_ready=!full.
module con_bus_ctrl
  import con_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CONS   = 3,
  parameter int META_WIDTH = 16,
  parameter int TX_DEPTH   = 4,
  parameter int TURNAROUND = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  con_bus_ctrl_if.master       bus,
  output logic [CNT_WIDTH-1:0] energy,
  output logic                 busy
);
  localparam int BW = beat_bits(NUM_CONS, DATA_WIDTH);
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [TW-1:0]        TURN_INIT = TW'(TURNAROUND - 1);
  localparam logic [CNT_WIDTH-1:0] BEAT_INC  = CNT_WIDTH'(BW);

  typedef struct packed {
    logic [META_WIDTH-1:0] meta;
    logic [BW-1:0]         data;
  } beat_t;

  con_state_e            state_q, state_d;
  logic [TW-1:0]         turn_cnt_q, turn_cnt_d;
  logic [BW-1:0]         rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [BW-1:0]         con_out_q, con_out_d;
  logic [META_WIDTH-1:0] out_meta_q, out_meta_d;
  logic                  out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]  energy_q, energy_d;

  logic  con_ready, accept, push, pop, full, empty;
  beat_t wr_beat, rd_beat;

  assign wr_beat = '{meta: bus.tx_meta, data: bus.tx_data};
  assign push    = bus.tx_valid && !full;

  con_tx_fifo #(
    .DEPTH(TX_DEPTH),
    .WIDTH($bits(beat_t))
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr_data(wr_beat),
    .rd_data(rd_beat),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    state_d     = state_q;
    turn_cnt_d  = turn_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    con_out_d   = con_out_q;
    out_meta_d  = out_meta_q;
    out_valid_d = 1'b0;
    con_ready   = 1'b0;
    pop         = 1'b0;

    case (state_q)
      RX: begin
        con_ready = !rx_valid_q || bus.rx_ready;
        // Leave RX once results are waiting and the env is idle, or the FIFO can take no more.
        if (!empty && (full || !bus.con_valid)) begin
          state_d    = TURN_TX;
          turn_cnt_d = TURN_INIT;
        end
      end
      TURN_TX: begin
        if (turn_cnt_q == '0) state_d = TX;
        else                  turn_cnt_d = turn_cnt_q - TW'(1);
      end
      TX: begin
        if (!empty) begin
          pop         = 1'b1;
          con_out_d   = rd_beat.data;
          out_meta_d  = rd_beat.meta;
          out_valid_d = 1'b1;
        end else begin
          state_d    = TURN_RX;
          turn_cnt_d = TURN_INIT;
        end
      end
      TURN_RX: begin
        if (turn_cnt_q == '0) state_d = RX;
        else                  turn_cnt_d = turn_cnt_q - TW'(1);
      end
      default: state_d = RX;
    endcase

    accept = bus.con_valid && con_ready;
    if (accept) begin
      rx_data_d  = bus.con_in;
      rx_valid_d = 1'b1;
    end else if (bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end

    energy_d = energy_q + (accept ? BEAT_INC : '0) + (out_valid_q ? BEAT_INC : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX;
      turn_cnt_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      con_out_q   <= '0;
      out_meta_q  <= '0;
      out_valid_q <= 1'b0;
      energy_q    <= '0;
    end else begin
      state_q     <= state_d;
      turn_cnt_q  <= turn_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      con_out_q   <= con_out_d;
      out_meta_q  <= out_meta_d;
      out_valid_q <= out_valid_d;
      energy_q    <= energy_d;
    end
  end

  assign bus.con_ready        = con_ready;
  assign bus.dut_driving_cons = (state_q == TX);
  assign bus.rx_data          = rx_data_q;
  assign bus.rx_valid         = rx_valid_q;
  assign bus.tx_ready         = !full;
  assign bus.con_out          = con_out_q;
  assign bus.output_meta      = out_meta_q;
  assign bus.output_valid     = out_valid_q;
  assign energy               = energy_q;
  assign busy                 = (state_q != RX) || !empty || rx_valid_q;

endmodule

// File: tb/tb_con_bus_ctrl.sv
// Directed bench for con_bus_ctrl: RX backpressure, TX bursts, full-forced switch,
// push/pop streaming, mid-TX reset, and an 8-bit energy counter wrap on a twin instance.
module tb_con_bus_ctrl;
  import con_bus_pkg::*;

  localparam int DW = 16;
  localparam int NC = 3;
  localparam int MW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] energy;
  logic        busy;
  logic [7:0]  energy8;
  logic        busy8;

  always #5 clk = ~clk;

  con_bus_ctrl_if #(.DATA_WIDTH(DW), .NUM_CONS(NC), .META_WIDTH(MW)) bus ();
  con_bus_ctrl_if #(.DATA_WIDTH(DW), .NUM_CONS(NC), .META_WIDTH(MW)) bus8 ();

  con_bus_ctrl #(
    .DATA_WIDTH(DW), .NUM_CONS(NC), .META_WIDTH(MW),
    .TX_DEPTH(4), .TURNAROUND(1), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .energy(energy), .busy(busy)
  );

  con_bus_ctrl #(
    .DATA_WIDTH(DW), .NUM_CONS(NC), .META_WIDTH(MW),
    .TX_DEPTH(4), .TURNAROUND(1), .CNT_WIDTH(8)
  ) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .energy(energy8), .busy(busy8)
  );

  assign bus8.con_in    = bus.con_in;
  assign bus8.con_valid = bus.con_valid;
  assign bus8.rx_ready  = bus.rx_ready;
  assign bus8.tx_data   = bus.tx_data;
  assign bus8.tx_meta   = bus.tx_meta;
  assign bus8.tx_valid  = bus.tx_valid;

  int n_checks = 0;
  int n_errors = 0;
  int sent, got;
  logic acc, cons;
  logic [15:0] drv_tr, ov_tr, crdy_tr, trdy_tr;
  con_beat_t b, e;

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] rx_beat(input int i);
    return {16'(i + 'h300), 16'(i + 'h200), 16'(i)};
  endfunction

  function automatic con_beat_t tx_beat(input int i);
    con_beat_t t;
    t.data = {16'(i + 'h3000), 16'(i + 'h2000), 16'(i + 'h1000)};
    t.meta = 16'(i + 'h0100);
    return t;
  endfunction

  task automatic check_idle(input string pfx);
    check({pfx, "_con_ready"},   64'(bus.con_ready),        64'd1);
    check({pfx, "_rx_valid"},    64'(bus.rx_valid),         64'd0);
    check({pfx, "_rx_data"},     64'(bus.rx_data),          64'd0);
    check({pfx, "_driving"},     64'(bus.dut_driving_cons), 64'd0);
    check({pfx, "_out_valid"},   64'(bus.output_valid),     64'd0);
    check({pfx, "_con_out"},     64'(bus.con_out),          64'd0);
    check({pfx, "_out_meta"},    64'(bus.output_meta),      64'd0);
    check({pfx, "_tx_ready"},    64'(bus.tx_ready),         64'd1);
    check({pfx, "_energy"},      64'(energy),               64'd0);
    check({pfx, "_busy"},        64'(busy),                 64'd0);
  endtask

  // Runs n cycles of a TX scenario, recording per-cycle traces and checking driven beats.
  // tx_sel: 0 = burst, 1 = full-forced, 2 = streaming.
  task automatic run_tx(input int n, input int tx_sel);
    drv_tr = '0; ov_tr = '0; crdy_tr = '0; trdy_tr = '0;
    for (int k = 0; k < n; k++) begin
      case (tx_sel)
        0: begin bus.tx_valid = (k < 3); b = tx_beat(k); end
        1: begin bus.tx_valid = (k < 4); b = tx_beat(k + 10); bus.con_valid = (k < 12); end
        default: begin
          bus.tx_valid = (k == 0) || (k >= 3 && k <= 6);
          b = tx_beat((k == 0) ? 20 : k + 18);
        end
      endcase
      bus.tx_data = b.data;
      bus.tx_meta = b.meta;
      #1;
      drv_tr[k]  = bus.dut_driving_cons;
      ov_tr[k]   = bus.output_valid;
      crdy_tr[k] = bus.con_ready;
      trdy_tr[k] = bus.tx_ready;
      if (bus.output_valid) begin
        case (tx_sel)
          0:       e = tx_beat(k - 4);
          1:       e = tx_beat(k - 7 + 10);
          default: e = tx_beat(k - 4 + 20);
        endcase
        check($sformatf("tx%0d_data_c%0d", tx_sel, k), 64'(bus.con_out), 64'(e.data));
        check($sformatf("tx%0d_meta_c%0d", tx_sel, k), 64'(bus.output_meta), 64'(e.meta));
      end
      step();
    end
    bus.tx_valid  = 1'b0;
    bus.con_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.con_in    = '0;
    bus.con_valid = 1'b0;
    bus.rx_ready  = 1'b0;
    bus.tx_data   = '0;
    bus.tx_meta   = '0;
    bus.tx_valid  = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check_idle("init");

    // RX with rx_ready toggling every cycle.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      bus.rx_ready  = (cyc % 2 == 1);
      bus.con_valid = (sent < 5);
      bus.con_in    = rx_beat(sent + 1);
      #1;
      acc  = bus.con_valid && bus.con_ready;
      cons = bus.rx_valid && bus.rx_ready;
      if (cons) begin
        check($sformatf("rx_beat%0d", got + 1), 64'(bus.rx_data), 64'(rx_beat(got + 1)));
        got++;
      end
      step();
      if (acc) sent++;
    end
    bus.con_valid = 1'b0;
    bus.rx_ready  = 1'b0;
    check("rx_count",  64'(got),    64'd5);
    check("rx_energy", 64'(energy), 64'd240);

    // Sixth beat: 288 bits total, 8-bit twin wraps to 32.
    bus.con_valid = 1'b1;
    bus.con_in    = rx_beat(6);
    bus.rx_ready  = 1'b1;
    step();
    bus.con_valid = 1'b0;
    #1;
    check("rx6_valid",    64'(bus.rx_valid), 64'd1);
    check("rx6_data",     64'(bus.rx_data),  64'(rx_beat(6)));
    check("energy_288",   64'(energy),       64'd288);
    check("energy8_wrap", 64'(energy8),      64'd32);
    step();
    check("rx6_cleared",  64'(bus.rx_valid), 64'd0);
    bus.rx_ready = 1'b0;

    // TX burst of 3 with env idle.
    run_tx(9, 0);
    check("burst_drv_trace",  64'(drv_tr),  64'h0078);
    check("burst_ov_trace",   64'(ov_tr),   64'h0070);
    check("burst_crdy_trace", 64'(crdy_tr), 64'h0103);
    check("burst_energy",     64'(energy),  64'd432);
    check("burst_busy",       64'(busy),    64'd0);

    // Env keeps con_valid high; switch is forced by a full FIFO.
    bus.rx_ready = 1'b1;
    bus.con_in   = rx_beat(7);
    run_tx(13, 1);
    bus.rx_ready = 1'b0;
    check("full_drv_trace",  64'(drv_tr),  64'h07C0);
    check("full_ov_trace",   64'(ov_tr),   64'h0780);
    check("full_crdy_trace", 64'(crdy_tr), 64'h101F);
    check("full_trdy_trace", 64'(trdy_tr), 64'h1F8F);
    check("full_energy",     64'(energy),  64'd864);

    // Push every TX cycle at depth 1: unbroken output stream.
    run_tx(11, 2);
    check("stream_drv_trace",  64'(drv_tr),  64'h01F8);
    check("stream_ov_trace",   64'(ov_tr),   64'h01F0);
    check("stream_trdy_trace", 64'(trdy_tr), 64'h07FF);
    check("stream_energy",     64'(energy),  64'd1104);

    // Reset while driving with a beat still queued.
    bus.tx_valid = 1'b1;
    b = tx_beat(30); bus.tx_data = b.data; bus.tx_meta = b.meta;
    step();
    b = tx_beat(31); bus.tx_data = b.data; bus.tx_meta = b.meta;
    step();
    bus.tx_valid = 1'b0;
    step();
    step();
    check("mtx_driving", 64'(bus.dut_driving_cons), 64'd1);
    check("mtx_ov",      64'(bus.output_valid),     64'd1);
    rst = 1'b1;
    step();
    check("mtx_rst_drv", 64'(bus.dut_driving_cons), 64'd0);
    step();
    rst = 1'b0;
    #1;
    check_idle("mtx_rst");
    step();
    step();
    step();
    check("post_rst_drv",  64'(bus.dut_driving_cons), 64'd0);
    check("post_rst_busy", 64'(busy),                 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
